fft_stage_control: RTL and testbench

FFT_STAGE_CONTROL -- requirements
Module: fft_stage_control

---
 rtl/fft_stage_control.sv | 229 ++++++++++++++++++++++
 tb/tb_fft_stage_control.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_control.sv
// ---------------------------------------------------------------------------
// fft_stage_control
//
// Address and routing sequencer for one radix-2 stage of an in-place FFT.
// The FFT data lives in four banks of 2^(NUMSTAGES-2) words each. During a
// stage, each read cycle fetches one butterfly operand pair. The matching
// write-back address and result swap come out LAT cycles later, which lines
// them up with the butterfly pipeline output.
//
// Control is level-sensitive rather than a valid/ready handshake. The
// controller runs a stage only while ld_data_r && en_r are both held high.
// Dropping either input aborts the stage back to IDLE on the next edge.
// stage_done stays high for as long as the completed stage is held.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous active-high reset
//   ld_data_r    in   1      input data loaded; 0 keeps / returns to IDLE
//   en_r         in   1      run current stage; 0 returns to IDLE
//   stage_num_r  in   3      stage index, sampled only when leaving IDLE
//   m0_s         out  1      cross-address pairing enable
//   m1_s         out  2      bank-pairing route select
//   m2_s         out  1      read-side operand swap
//   m3_s         out  1      write-side result swap (m2_s delayed LAT)
//   r_addr_0_1   out  AW     read address, banks 0/1
//   r_addr_2_3   out  AW     read address, banks 2/3
//   w_addr_0_1   out  AW     write address, banks 0/1 (r_addr_0_1 delayed LAT)
//   w_addr_2_3   out  AW     write address, banks 2/3 (r_addr_2_3 delayed LAT)
//   stage_done   out  1      stage complete (held in DONE)
//   dbg_state_o  out  2      current FSM state (IDLE=0 READ=1 DRAIN=2 DONE=3)
//
// Every output comes straight from a flop. LAT must be at least 1.
// ---------------------------------------------------------------------------
module fft_stage_control #(
    parameter int NUMSTAGES = 5,
    parameter int LAT       = 2,
    localparam int AW       = NUMSTAGES - 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_data_r,
    input  logic          en_r,
    input  logic [2:0]    stage_num_r,
    output logic          m0_s,
    output logic [1:0]    m1_s,
    output logic          m2_s,
    output logic          m3_s,
    output logic [AW-1:0] r_addr_0_1,
    output logic [AW-1:0] w_addr_0_1,
    output logic [AW-1:0] r_addr_2_3,
    output logic [AW-1:0] w_addr_2_3,
    output logic          stage_done,
    output logic [1:0]    dbg_state_o
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [AW-1:0] JMAX = {AW{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] j_q, j_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    s_q, s_d;

    // Next values of the registered outputs.
    logic [AW-1:0] r01_d, r23_d, mask_d;
    logic          m0_d, m2_d, done_d;
    logic [1:0]    m1_d;
    logic          go;
    logic          pass_d;
    int            s_int;

    // Delay lines from the read side to the write side. Tap LAT-1 holds the
    // read-side value from LAT cycles earlier.
    logic [AW-1:0] dl01_q [LAT];
    logic [AW-1:0] dl23_q [LAT];
    logic          dlm2_q [LAT];

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        go      = ld_data_r && en_r;

        if (!go) begin
            // Any state: losing ld/en aborts and flushes the stage.
            state_d = IDLE;
            j_d     = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    s_d     = stage_num_r;
                    j_d     = '0;
                    cnt_d   = '0;
                    state_d = (int'(stage_num_r) < NUMSTAGES) ? READ : DONE;
                end
                READ: begin
                    if (j_q == JMAX) begin
                        state_d = DRAIN;
                        j_d     = '0;
                        cnt_d   = '0;
                    end else begin
                        j_d = j_q + AW'(1);
                    end
                end
                DRAIN: begin
                    if (cnt_q == CW'(LAT - 1)) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output decode from the next state. This lets the outputs be registered
    // and still line up with the state they describe.
    always_comb begin
        s_int  = int'(s_d);
        pass_d = (s_int >= NUMSTAGES);

        // For stages 2..NUMSTAGES-1 the butterfly partner of word j sits in
        // the other bank pair at j with one address bit flipped. The bit moves
        // from the MSB (stage 2) down to the LSB (last stage).
        if (!pass_d && s_int >= 2) begin
            mask_d = AW'(1) << (NUMSTAGES - 1 - s_int);
        end else begin
            mask_d = '0;
        end

        if (state_d == READ) begin
            r01_d = j_d;
            r23_d = j_d ^ mask_d;
            m2_d  = |(j_d & mask_d);
        end else begin
            r01_d = '0;
            r23_d = '0;
            m2_d  = 1'b0;
        end

        // Route selects hold for the whole stage, including DONE.
        m0_d = 1'b0;
        m1_d = 2'd0;
        if (state_d != IDLE) begin
            if (pass_d) begin
                m1_d = 2'd3;
            end else if (s_int == 0) begin
                m1_d = 2'd0;
            end else if (s_int == 1) begin
                m1_d = 2'd1;
            end else begin
                m1_d = 2'd2;
                m0_d = 1'b1;
            end
        end

        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            j_q        <= '0;
            cnt_q      <= '0;
            s_q        <= '0;
            r_addr_0_1 <= '0;
            r_addr_2_3 <= '0;
            m0_s       <= 1'b0;
            m1_s       <= 2'd0;
            m2_s       <= 1'b0;
            stage_done <= 1'b0;
            for (int i = 0; i < LAT; i++) begin
                dl01_q[i] <= '0;
                dl23_q[i] <= '0;
                dlm2_q[i] <= 1'b0;
            end
        end else begin
            state_q    <= state_d;
            j_q        <= j_d;
            cnt_q      <= cnt_d;
            s_q        <= s_d;
            r_addr_0_1 <= r01_d;
            r_addr_2_3 <= r23_d;
            m0_s       <= m0_d;
            m1_s       <= m1_d;
            m2_s       <= m2_d;
            stage_done <= done_d;
            if (state_d == IDLE) begin
                // Abort or exit: drop any writes still in flight.
                for (int i = 0; i < LAT; i++) begin
                    dl01_q[i] <= '0;
                    dl23_q[i] <= '0;
                    dlm2_q[i] <= 1'b0;
                end
            end else begin
                dl01_q[0] <= r_addr_0_1;
                dl23_q[0] <= r_addr_2_3;
                dlm2_q[0] <= m2_s;
                for (int i = 1; i < LAT; i++) begin
                    dl01_q[i] <= dl01_q[i-1];
                    dl23_q[i] <= dl23_q[i-1];
                    dlm2_q[i] <= dlm2_q[i-1];
                end
            end
        end
    end

    assign w_addr_0_1  = dl01_q[LAT-1];
    assign w_addr_2_3  = dl23_q[LAT-1];
    assign m3_s        = dlm2_q[LAT-1];
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fft_stage_control.sv
module tb_fft_stage_control;

    localparam int NS  = 5;
    localparam int LAT = 2;
    localparam int AW  = NS - 2;
    localparam int NJ  = 1 << AW;
    localparam int W   = 6 + 4 * AW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic ld, en;
    logic [2:0] stg;

    always #5 clk = ~clk;

    logic          m0_s, m2_s, m3_s, stage_done;
    logic [1:0]    m1_s, dbg_state;
    logic [AW-1:0] r_addr_0_1, w_addr_0_1, r_addr_2_3, w_addr_2_3;

    fft_stage_control #(.NUMSTAGES(NS), .LAT(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .ld_data_r   (ld),
        .en_r        (en),
        .stage_num_r (stg),
        .m0_s        (m0_s),
        .m1_s        (m1_s),
        .m2_s        (m2_s),
        .m3_s        (m3_s),
        .r_addr_0_1  (r_addr_0_1),
        .w_addr_0_1  (w_addr_0_1),
        .r_addr_2_3  (r_addr_2_3),
        .w_addr_2_3  (w_addr_2_3),
        .stage_done  (stage_done),
        .dbg_state_o (dbg_state)
    );

    logic [W-1:0] dut_vec;
    assign dut_vec = {stage_done, m0_s, m1_s, m2_s, m3_s,
                      r_addr_0_1, r_addr_2_3, w_addr_0_1, w_addr_2_3};

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int tests_run    = 0;
    int tests_failed = 0;

    // ---------------- reference model ----------------
    // Timeline view: a stage started at edge t=0 reads word t for t<NJ,
    // writes word t-LAT for LAT<=t<LAT+NJ, and is done from t=NJ+LAT onward.
    bit m_active = 1'b0;
    int m_s = 0;
    int m_t = 0;

    // Butterfly partner of word j in the other bank pair, for stage s >= 2.
    function automatic void partner(input int s, input int j,
                                    output int addr23, output bit swap);
        int half;
        if (s < 2) begin
            addr23 = j;
            swap   = 1'b0;
        end else begin
            half   = NJ >> (s - 1);
            swap   = ((j / half) % 2) == 1;
            addr23 = swap ? j - half : j + half;
        end
    endfunction

    function automatic logic [W-1:0] model_out();
        logic done, m0, m2, m3;
        logic [1:0] m1;
        logic [AW-1:0] r01, r23, w01, w23;
        int a23;
        bit sw;
        done = 0; m0 = 0; m1 = 0; m2 = 0; m3 = 0;
        r01 = 0; r23 = 0; w01 = 0; w23 = 0;
        if (m_active) begin
            if (m_s >= NS) begin
                m1   = 2'd3;
                done = 1'b1;
            end else begin
                m0 = (m_s >= 2);
                m1 = (m_s == 0) ? 2'd0 : (m_s == 1) ? 2'd1 : 2'd2;
                if (m_t < NJ) begin
                    partner(m_s, m_t, a23, sw);
                    r01 = AW'(m_t);
                    r23 = AW'(a23);
                    m2  = sw;
                end
                if (m_t >= LAT && m_t < LAT + NJ) begin
                    partner(m_s, m_t - LAT, a23, sw);
                    w01 = AW'(m_t - LAT);
                    w23 = AW'(a23);
                    m3  = sw;
                end
                done = (m_t >= NJ + LAT);
            end
        end
        return {done, m0, m1, m2, m3, r01, r23, w01, w23};
    endfunction

    // Advance the model across the coming rising edge and queue the outputs.
    task automatic model_step();
        if (rst || !(ld && en)) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_s      = int'(stg);
            m_t      = 0;
        end else begin
            m_t++;
        end
        exp_q.push_back(model_out());
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit l, input bit e, input logic [2:0] st);
        @(negedge clk);
        ld  = l;
        en  = e;
        stg = st;
        model_step();
    endtask

    task automatic run_stage(input logic [2:0] st, input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, st);
    endtask

    task automatic check_zero(input string name);
        tests_run++;
        if (dut_vec !== '0) begin
            tests_failed++;
            $display("FAIL %s: got %h, want 0", name, dut_vec);
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        logic [W-1:0] exp;
        #1;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            tests_run++;
            if (dut_vec !== exp) begin
                tests_failed++;
                $display("FAIL outputs @%0t (ld=%0b en=%0b stg=%0d): got %h, want %h",
                         $time, ld, en, stg, dut_vec, exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; ld = 1'b0; en = 1'b0; stg = 3'd0;
        #2;
        check_zero("reset_state");
        drive(1'b0, 1'b0, 3'd0);
        drive(1'b1, 1'b1, 3'd0);      // reset still held: must not start
        @(negedge clk);
        rst = 1'b0; ld = 1'b0; en = 1'b0;
        model_step();

        // Stage 0, 2 and 4: full run, hold DONE, then drop en.
        run_stage(3'd0, 14); drive(1'b1, 1'b0, 3'd0);
        run_stage(3'd2, 14); drive(1'b1, 1'b0, 3'd2);
        run_stage(3'd4, 14); drive(1'b1, 1'b0, 3'd4);

        // Stages 0..5 in sequence, en low for one cycle between.
        for (int s = 0; s < 6; s++) begin
            run_stage(3'(s), (s < NS) ? NJ + LAT + 2 : 2);
            drive(1'b1, 1'b0, 3'(s));
        end
        run_stage(3'd7, 3); drive(1'b1, 1'b0, 3'd7);

        // Abort at j=3, then restart with a new stage number.
        run_stage(3'd1, 4);
        drive(1'b1, 1'b0, 3'd1);
        run_stage(3'd3, 13);

        // stage_num changes mid-stage are ignored.
        drive(1'b0, 1'b1, 3'd3);
        drive(1'b1, 1'b1, 3'd2);
        for (int i = 0; i < 12; i++) drive(1'b1, 1'b1, 3'($urandom_range(0, 7)));
        drive(1'b1, 1'b0, 3'd0);

        // Asynchronous reset in the first DRAIN cycle.
        run_stage(3'd3, NJ + 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero("rst_mid_drain");
        model_step();
        drive(1'b1, 1'b1, 3'd3);
        @(negedge clk);
        rst = 1'b0; ld = 1'b0; en = 1'b1;
        model_step();

        // ld low with en high: stays idle.
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 3'($urandom_range(0, 7)));

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 24) != 0, $urandom_range(0, 19) != 0,
                  3'($urandom_range(0, 7)));
        end

        drive(1'b0, 1'b0, 3'd0);
        drive(1'b0, 1'b0, 3'd0);
        @(posedge clk);
        #3;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
